spi_slave: RTL and testbench

SPI peripheral-side endpoint that pairs with `spi_master` on the same four-wire bus (SCLK, MOSI, MISO, SS). It oversamples the bus in the system clock domain, shifts MOSI into a receive register and shifts a transmit byte out on MISO, MSB first. All four SPI modes are supported via `cpol`/`cpha`. Received bytes go to the core as a one-cycle `rx_valid` pulse with `data_out`.

---
 rtl/spi_slave.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI peripheral endpoint, all four modes, oversampled in the clk domain
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS,
    output logic                  MISO,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rx_valid,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ss_sync_q;
    logic                   sclk_prev_q;
    logic                   ss_prev_q;
    logic                   lead_q;
    logic                   trail_q;
    logic                   ss_fall_q;

    logic sclk_s;
    logic mosi_s;
    logic ss_s;

    state_t                state_q,    state_d;
    logic                  cpol_q,     cpol_d;
    logic                  cpha_q,     cpha_d;
    logic [CNT_W-1:0]      bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  miso_q,     miso_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  reload_q,   reload_d;

    logic                  sample_edge;
    logic                  shift_edge;
    logic [DATA_WIDTH-1:0] rx_next;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];

    // SS syncs reset low so a select already held low across reset never looks like a fresh fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            lead_q      <= 1'b0;
            trail_q     <= 1'b0;
            ss_fall_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS};
            sclk_prev_q <= sclk_s;
            ss_prev_q   <= ss_s;
            lead_q      <= (sclk_prev_q == cpol_q) && (sclk_s != cpol_q);
            trail_q     <= (sclk_prev_q != cpol_q) && (sclk_s == cpol_q);
            ss_fall_q   <= ss_prev_q && !ss_s;
        end
    end

    assign sample_edge = cpha_q ? trail_q : lead_q;
    assign shift_edge  = cpha_q ? lead_q  : trail_q;
    assign rx_next     = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            data_out_q <= '0;
            miso_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            data_out_q <= data_out_d;
            miso_q     <= miso_d;
            rx_valid_q <= rx_valid_d;
            reload_q   <= reload_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        data_out_d = data_out_q;
        miso_d     = miso_q;
        rx_valid_d = 1'b0;
        reload_d   = reload_q;

        case (state_q)
            IDLE: begin
                // A frame load wins over any SCLK edge seen in the same cycle.
                if (ss_fall_q) begin
                    state_d   = ACTIVE;
                    cpol_d    = cpol;
                    cpha_d    = cpha;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                    if (cpha) begin
                        tx_shift_d = data_in;
                        miso_d     = 1'b0;
                    end else begin
                        tx_shift_d = data_in << 1;
                        miso_d     = data_in[DATA_WIDTH-1];
                    end
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                    reload_d  = 1'b0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            data_out_d = rx_next;
                            rx_valid_d = 1'b1;
                            bit_cnt_d  = '0;
                            reload_d   = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    // The shift edge after a completion fetches the next transmit word.
                    if (shift_edge) begin
                        if (reload_q) begin
                            miso_d     = data_in[DATA_WIDTH-1];
                            tx_shift_d = data_in << 1;
                            reload_d   = 1'b0;
                        end else begin
                            miso_d     = tx_shift_q[DATA_WIDTH-1];
                            tx_shift_d = tx_shift_q << 1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MISO     = miso_q;
    assign data_out = data_out_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - master-side model driving spi_slave, checked against byte-level expectations
module tb_spi_slave;

    localparam int H = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       SCLK, MOSI, SS, cpol, cpha;
    logic       MISO, rx_valid, busy;
    logic [7:0] data_in, data_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] rxq[$];
    logic [7:0] m_rx[$];
    logic [7:0] mosi_q[$];
    logic [7:0] din_q[$];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .cpol(cpol), .cpha(cpha), .data_in(data_in), .data_out(data_out),
        .rx_valid(rx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rx_valid === 1'b1) rxq.push_back(data_out);

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Master side: shifts mosi_q out MSB first, collects MISO at its sample edges into m_rx.
    task automatic spi_frame(input bit pol, input bit pha, input int nbits, input bit raise_ss);
        logic [7:0] mb;
        logic [7:0] rb;
        int         byte_i, bit_i;
        rb = '0;
        @(negedge clk);
        cpol = pol; cpha = pha; SCLK = pol; data_in = din_q[0];
        idle(4);
        SS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            byte_i = i / 8;
            bit_i  = 7 - (i % 8);
            mb     = mosi_q[byte_i];
            if (bit_i == 0 && byte_i + 1 < din_q.size()) data_in = din_q[byte_i + 1];
            if (!pha) begin
                MOSI = mb[bit_i];
                idle(H);
                rb[bit_i] = MISO;
                SCLK = ~pol;
                idle(H);
                SCLK = pol;
            end else begin
                idle(H);
                SCLK = ~pol;
                MOSI = mb[bit_i];
                idle(H);
                rb[bit_i] = MISO;
                SCLK = pol;
            end
            if (bit_i == 0) m_rx.push_back(rb);
        end
        idle(H);
        if (raise_ss) SS = 1'b1;
        idle(8);
    endtask

    task automatic run_and_check(input string tag, input bit pol, input bit pha);
        int base;
        base = rxq.size();
        m_rx.delete();
        spi_frame(pol, pha, mosi_q.size() * 8, 1'b1);
        chk({tag, "_nvalid"}, rxq.size() - base, mosi_q.size());
        for (int i = 0; i < mosi_q.size(); i++) begin
            if (base + i < rxq.size()) chk({tag, "_rx"}, rxq[base + i], mosi_q[i]);
            if (i < m_rx.size()) chk({tag, "_master_rx"}, m_rx[i], din_q[i]);
        end
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_miso_end"}, MISO, 1'b0);
    endtask

    initial begin
        int         base;
        logic [7:0] prev;
        bit         bad;
        bit         rp, rh;
        int         nb;

        reset = 1'b1; SCLK = 1'b0; MOSI = 1'b0; SS = 1'b1;
        cpol = 1'b0; cpha = 1'b0; data_in = '0;
        idle(3);
        chk("rst_miso", MISO, 1'b0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        idle(5);

        mosi_q = '{8'hAA}; din_q = '{8'hCC};
        run_and_check("mode0", 1'b0, 1'b0);
        mosi_q = '{8'h3C}; din_q = '{8'h5A};
        run_and_check("mode3", 1'b1, 1'b1);
        mosi_q = '{8'h7E}; din_q = '{8'h81};
        run_and_check("mode1", 1'b0, 1'b1);
        mosi_q = '{8'h0F}; din_q = '{8'hF0};
        run_and_check("mode2", 1'b1, 1'b0);

        // Partial frame is discarded
        prev = data_out;
        base = rxq.size();
        mosi_q = '{8'hFF}; din_q = '{8'h55};
        spi_frame(1'b0, 1'b0, 5, 1'b1);
        chk("partial_nvalid", rxq.size() - base, 0);
        chk("partial_data_out", data_out, prev);
        chk("partial_miso", MISO, 1'b0);
        chk("partial_busy", busy, 1'b0);
        mosi_q = '{8'h96}; din_q = '{8'h69};
        run_and_check("after_partial", 1'b0, 1'b0);

        mosi_q = '{8'h12, 8'h34}; din_q = '{8'hA5, 8'h3C};
        run_and_check("b2b", 1'b0, 1'b0);

        // Reset in the middle of a frame
        base = rxq.size();
        mosi_q = '{8'hE7}; din_q = '{8'hFF};
        spi_frame(1'b0, 1'b0, 4, 1'b0);
        chk("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_miso", MISO, 1'b0);
        chk("midrst_data_out", data_out, 8'h00);
        chk("midrst_rx_valid", rx_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        idle(3);
        reset = 1'b0;
        idle(3);
        chk("post_rst_busy", busy, 1'b0);
        SS = 1'b1;
        idle(8);
        chk("midrst_nvalid", rxq.size() - base, 0);
        mosi_q = '{8'hC3}; din_q = '{8'h3E};
        run_and_check("after_reset", 1'b0, 1'b0);

        // SCLK activity while deselected
        base = rxq.size();
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            SCLK = ~SCLK;
            MOSI = $urandom_range(0, 1);
            repeat (H) begin
                @(negedge clk);
                if (busy !== 1'b0 || MISO !== 1'b0) bad = 1'b1;
            end
        end
        chk("ss_high_quiet", bad, 1'b0);
        chk("ss_high_nvalid", rxq.size() - base, 0);

        for (int k = 0; k < 8; k++) begin
            rp = $urandom_range(0, 1);
            rh = $urandom_range(0, 1);
            nb = $urandom_range(1, 3);
            mosi_q.delete(); din_q.delete();
            for (int j = 0; j < nb; j++) begin
                mosi_q.push_back(8'($urandom));
                din_q.push_back(8'($urandom));
            end
            run_and_check($sformatf("rand%0d", k), rp, rh);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
